dds_command_encoder: RTL and testbench
======================================

Name: dds_command_encoder

Overview:
- Host-side encoder for DDS channel command words: the inverse of the DDS controller's decoder.
- Accepts one parameter-update request (frequency, amplitude, phase, amplitude offset, time offset, sync) with a start timestamp.
- Emits the minimal sequence of 128-bit timed words ({timestamp[63:0], opcode[3:0], payload[59:0]}) on an AXI-Stream-style port into the channel's timed FIFO.
- Keeps shadow copies of the decoder's freq/amp/phase registers so partial-frequency opcodes are used whenever they suffice.

Parameters:
- TS_STEP, 64'd1, timestamp increment between consecutive words of one request (decoder consumes one word per clock).

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  encoder can accept a request.
- req_mask  in  7  bit0 freq, bit1 amp, bit2 phase, bit3 amp_offset, bit4 time_offset, bit5 sync, bit6 force_full_freq.
- req_freq  in  48  new frequency word.
- req_amp  in  14  new amplitude (unsigned).
- req_phase  in  14  new phase.
- req_amp_offset  in  14  new amplitude offset.
- req_time_offset  in  60  new time offset.
- req_timestamp  in  64  timestamp of the first emitted word.
- cmd_tdata  out  128  command word.
- cmd_tvalid  out  1  word valid.
- cmd_tready  in  1  FIFO accepts word.
- cmd_tlast  out  1  last word of the current request.
- busy  out  1  request in progress (not IDLE).

Behaviour:
- Reset (async, resetn=0): req_ready=0, cmd_tvalid=0, cmd_tlast=0, cmd_tdata=0, busy=0, shadow freq/amp/phase=0 (matches decoder reset), FSM=IDLE. Mid-request reset discards the request; the partially sent sequence is not resumed.
- FSM states:
  - IDLE: req_ready=1. On req_valid&req_ready, latch all req_* → PLAN.
  - PLAN: one cycle. Build a 5-bit word plan, commit shadows → EMIT, or → IDLE if the plan is empty. An empty mask is accepted and emits nothing.
  - EMIT: present words in plan order. Advance only on cmd_tvalid&cmd_tready. tdata and tlast stay stable while stalled. Last accept → IDLE.
- Latency: request accepted at cycle N; first cmd_tvalid at N+2; one word per cycle with cmd_tready held high.
- Plan order (each word only if selected):
  - TOFF: opcode 0100, payload = time_offset.
  - AOFF: opcode 0101, payload[13:0] = amp_offset, rest 0.
  - FAP_A: freq/amp/phase word.
  - FAP_B: opcode 1111.
  - SYNC: opcode 0001.
- Effective values: eff_amp/eff_phase/eff_freq = req value if the mask bit is set, else the shadow value.
- FAP payload: [59:46]=eff_amp, [45:32]=eff_phase, [31:0]=frequency window.
- Sync set (bit5):
  - FAP_A = 0000 with eff_freq[47:16], only if amp or phase is masked.
  - Then SYNC with payload[47:0]=eff_freq, [59:48]=0.
  - FAP_B unused.
- Sync clear, any of freq/amp/phase masked: diff = eff_freq ^ shadow_freq. Candidate windows, each 32 bits wide:
  - lo=16: opcode 0000, window [47:16].
  - lo=14-2k, k=0..7: opcode {1,k[2:0]}, window [45-2k:14-2k].
- Window selection:
  - Choose the largest lo with diff[lo-1:0]==0 and diff[47:lo+32]==0. diff==0 selects 0000.
  - No window fits, or force_full_freq set: FAP_A=0000 and FAP_B=1111 (eff_freq[31:0]).
- Opcodes 0010/0011 are never generated.
- Timestamps: word i (0-based within the request) carries req_timestamp + i*TS_STEP, mod 2^64.
- Shadows updated in PLAN: freq/amp/phase ← eff values.
- cmd_tlast high on the final planned word only.
- busy=1 in PLAN and EMIT.

Decomposition:
- dds_cmd_pkg holds:
  - opcode constants (OP_FAP, OP_SYNC, OP_TOFF, OP_AOFF, OP_WIN_BASE);
  - mask bit indices and payload field positions;
  - the plan-bit enum and the FSM state typedef.
- Sub-module dds_freq_window_select: combinational; inputs diff[47:0] and force; outputs fits, opcode[3:0], lo[4:0].

Test Plan:
- After reset: mask=freq, freq=48'h0000_0000_0100, ts=100 → one word, ts 100, opcode 1011, payload[31:0]=1, amp=phase=0, tlast=1.
- mask=freq|amp, freq=48'h1234_5678_0000, amp=14'h3FFF from reset → one 0000 word, data[31:0]=32'h1234_5678, [59:46]=3FFF.
- mask=freq, freq=48'h8000_0000_0001 from reset, ts=7 → 0000 (data 32'h8000_0000) at ts 7, then 1111 (data 32'h1) at ts 8.
- mask=all incl. sync, TS_STEP=1, ts=0 → 0100, 0101, 0000, 0001 at ts 0..3; tlast only on the 0001 word; the 0001 word carries the full 48-bit freq.
- cmd_tready low for 5 cycles mid-sequence → tdata/tvalid held unchanged, no word lost or duplicated, req_ready stays 0.
- resetn asserted while EMIT is stalled → tvalid drops immediately; the next request from freq 0 is encoded against zeroed shadows.

Source files
------------

// File: rtl/dds_cmd_pkg.sv
// rtl/dds_cmd_pkg.sv - shared opcodes, field positions and types for the DDS command encoder
package dds_cmd_pkg;

    localparam logic [3:0] OP_FAP      = 4'b0000;
    localparam logic [3:0] OP_SYNC     = 4'b0001;
    localparam logic [3:0] OP_TOFF     = 4'b0100;
    localparam logic [3:0] OP_AOFF     = 4'b0101;
    localparam logic [3:0] OP_WIN_BASE = 4'b1000;
    localparam logic [3:0] OP_FAP_B    = 4'b1111;

    localparam int M_FREQ  = 0;
    localparam int M_AMP   = 1;
    localparam int M_PHASE = 2;
    localparam int M_AOFF  = 3;
    localparam int M_TOFF  = 4;
    localparam int M_SYNC  = 5;
    localparam int M_FORCE = 6;

    localparam int PL_AMP_LSB   = 46;
    localparam int PL_PHASE_LSB = 32;

    typedef enum logic [2:0] {
        PB_TOFF  = 3'd0,
        PB_AOFF  = 3'd1,
        PB_FAP_A = 3'd2,
        PB_FAP_B = 3'd3,
        PB_SYNC  = 3'd4
    } plan_bit_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAN,
        ST_EMIT
    } state_e;

    // True when every set bit of diff lies inside the 32-bit window starting at lo.
    function automatic logic window_fits(input logic [47:0] diff, input int lo);
        logic [47:0] keep;
        keep = ((48'd1 << (lo + 32)) - 48'd1) & ~((48'd1 << lo) - 48'd1);
        return (diff & ~keep) == 48'd0;
    endfunction

endpackage

// File: rtl/dds_freq_window_select.sv
// rtl/dds_freq_window_select.sv - picks the partial-frequency opcode covering all changed bits
module dds_freq_window_select
    import dds_cmd_pkg::*;
(
    input  logic [47:0] diff,
    input  logic        force_full,
    output logic        fits,
    output logic [3:0]  opcode,
    output logic [4:0]  lo
);

    // Candidates are visited from lowest lo upward so the largest fitting one wins.
    always_comb begin
        fits   = 1'b0;
        opcode = OP_FAP;
        lo     = 5'd16;
        for (int k = 7; k >= 0; k--) begin
            if (window_fits(diff, 14 - 2 * k)) begin
                fits   = 1'b1;
                opcode = OP_WIN_BASE | 4'(k);
                lo     = 5'(14 - 2 * k);
            end
        end
        if (diff[15:0] == 16'd0) begin
            fits   = 1'b1;
            opcode = OP_FAP;
            lo     = 5'd16;
        end
        if (force_full) begin
            fits   = 1'b0;
            opcode = OP_FAP;
            lo     = 5'd16;
        end
    end

endmodule

// File: rtl/dds_command_encoder.sv
// rtl/dds_command_encoder.sv - turns one DDS parameter-update request into timed command words
module dds_command_encoder
    import dds_cmd_pkg::*;
#(
    parameter logic [63:0] TS_STEP = 64'd1
)
(
    input  logic         clk,
    input  logic         resetn,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [6:0]   req_mask,
    input  logic [47:0]  req_freq,
    input  logic [13:0]  req_amp,
    input  logic [13:0]  req_phase,
    input  logic [13:0]  req_amp_offset,
    input  logic [59:0]  req_time_offset,
    input  logic [63:0]  req_timestamp,
    output logic [127:0] cmd_tdata,
    output logic         cmd_tvalid,
    input  logic         cmd_tready,
    output logic         cmd_tlast,
    output logic         busy
);

    state_e       state, state_d;
    logic         ready_q;
    logic [6:0]   mask_q;
    logic [47:0]  freq_q, shadow_freq, eff_freq, diff;
    logic [13:0]  amp_q, phase_q, aoff_q, shadow_amp, shadow_phase, eff_amp, eff_phase;
    logic [59:0]  toff_q;
    logic [63:0]  ts_q;
    logic [4:0]   plan_q, plan_d;
    logic [3:0]   fap_op_q, fap_op_d, win_op, op;
    logic [4:0]   fap_lo_q, fap_lo_d, win_lo;
    logic         win_fits, accept, last_word;
    logic [31:0]  fap_window;
    logic [59:0]  payload;

    assign accept    = req_valid && ready_q;
    assign req_ready = ready_q;

    assign eff_freq  = mask_q[M_FREQ]  ? freq_q  : shadow_freq;
    assign eff_amp   = mask_q[M_AMP]   ? amp_q   : shadow_amp;
    assign eff_phase = mask_q[M_PHASE] ? phase_q : shadow_phase;
    assign diff      = eff_freq ^ shadow_freq;

    dds_freq_window_select u_window (
        .diff       (diff),
        .force_full (mask_q[M_FORCE]),
        .fits       (win_fits),
        .opcode     (win_op),
        .lo         (win_lo)
    );

    always_comb begin
        plan_d           = '0;
        fap_op_d         = OP_FAP;
        fap_lo_d         = 5'd16;
        plan_d[PB_TOFF]  = mask_q[M_TOFF];
        plan_d[PB_AOFF]  = mask_q[M_AOFF];
        if (mask_q[M_SYNC]) begin
            plan_d[PB_FAP_A] = mask_q[M_AMP] | mask_q[M_PHASE];
            plan_d[PB_SYNC]  = 1'b1;
        end else if (|mask_q[M_PHASE:M_FREQ]) begin
            plan_d[PB_FAP_A] = 1'b1;
            plan_d[PB_FAP_B] = !win_fits;
            fap_op_d         = win_op;
            fap_lo_d         = win_lo;
        end
    end

    // Remaining words live in plan_q; the lowest set bit is the one on the bus.
    assign last_word = (plan_q & (plan_q - 5'd1)) == 5'd0;

    always_comb begin
        state_d = state;
        busy    = (state != ST_IDLE);
        case (state)
            ST_IDLE: if (accept) state_d = ST_PLAN;
            ST_PLAN: state_d = (plan_d == 5'd0) ? ST_IDLE : ST_EMIT;
            ST_EMIT: if (cmd_tready && last_word) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Shadows are already committed by EMIT, so they hold the effective values.
    assign fap_window = 32'(shadow_freq >> fap_lo_q);

    always_comb begin
        op      = OP_FAP;
        payload = '0;
        if (plan_q[PB_TOFF]) begin
            op      = OP_TOFF;
            payload = toff_q;
        end else if (plan_q[PB_AOFF]) begin
            op      = OP_AOFF;
            payload = {46'd0, aoff_q};
        end else if (plan_q[PB_FAP_A]) begin
            op      = fap_op_q;
            payload = {shadow_amp, shadow_phase, fap_window};
        end else if (plan_q[PB_FAP_B]) begin
            op      = OP_FAP_B;
            payload = {shadow_amp, shadow_phase, shadow_freq[31:0]};
        end else if (plan_q[PB_SYNC]) begin
            op      = OP_SYNC;
            payload = {12'd0, shadow_freq};
        end
    end

    assign cmd_tvalid = (state == ST_EMIT);
    assign cmd_tdata  = cmd_tvalid ? {ts_q, op, payload} : '0;
    assign cmd_tlast  = cmd_tvalid && last_word;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            ready_q      <= 1'b0;
            mask_q       <= '0;
            freq_q       <= '0;
            amp_q        <= '0;
            phase_q      <= '0;
            aoff_q       <= '0;
            toff_q       <= '0;
            ts_q         <= '0;
            plan_q       <= '0;
            fap_op_q     <= OP_FAP;
            fap_lo_q     <= 5'd16;
            shadow_freq  <= '0;
            shadow_amp   <= '0;
            shadow_phase <= '0;
        end else begin
            state   <= state_d;
            ready_q <= (state_d == ST_IDLE);
            if (accept) begin
                mask_q  <= req_mask;
                freq_q  <= req_freq;
                amp_q   <= req_amp;
                phase_q <= req_phase;
                aoff_q  <= req_amp_offset;
                toff_q  <= req_time_offset;
                ts_q    <= req_timestamp;
            end
            if (state == ST_PLAN) begin
                plan_q       <= plan_d;
                fap_op_q     <= fap_op_d;
                fap_lo_q     <= fap_lo_d;
                shadow_freq  <= eff_freq;
                shadow_amp   <= eff_amp;
                shadow_phase <= eff_phase;
            end
            if (cmd_tvalid && cmd_tready) begin
                plan_q <= plan_q & (plan_q - 5'd1);
                ts_q   <= ts_q + TS_STEP;
            end
        end
    end

endmodule

// File: tb/tb_dds_command_encoder.sv
// tb/tb_dds_command_encoder.sv - scoreboard bench for dds_command_encoder
module tb_dds_command_encoder;

    typedef struct {
        logic [127:0] data;
        logic         last;
    } word_t;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [6:0]   req_mask = '0;
    logic [47:0]  req_freq = '0;
    logic [13:0]  req_amp = '0;
    logic [13:0]  req_phase = '0;
    logic [13:0]  req_amp_offset = '0;
    logic [59:0]  req_time_offset = '0;
    logic [63:0]  req_timestamp = '0;
    logic [127:0] cmd_tdata;
    logic         cmd_tvalid;
    logic         cmd_tready = 1'b1;
    logic         cmd_tlast;
    logic         busy;

    int    n_cmp = 0;
    int    n_err = 0;
    word_t exp_q[$];
    word_t got_q[$];
    logic  stall_force = 1'b0;
    logic  rand_mode = 1'b0;
    logic [47:0] sh_freq = '0;
    logic [13:0] sh_amp = '0, sh_phase = '0;

    dds_command_encoder dut (
        .clk             (clk),
        .resetn          (resetn),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_mask        (req_mask),
        .req_freq        (req_freq),
        .req_amp         (req_amp),
        .req_phase       (req_phase),
        .req_amp_offset  (req_amp_offset),
        .req_time_offset (req_time_offset),
        .req_timestamp   (req_timestamp),
        .cmd_tdata       (cmd_tdata),
        .cmd_tvalid      (cmd_tvalid),
        .cmd_tready      (cmd_tready),
        .cmd_tlast       (cmd_tlast),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cmd_tready = stall_force ? 1'b0 : (rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // Monitor: pops the scoreboard on every handshake, and checks held words while stalled.
    initial begin
        logic         hold = 1'b0;
        logic [127:0] hold_data = '0;
        logic         hold_last = 1'b0;
        word_t        e, g;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                hold = 1'b0;
            end else begin
                if (busy) check("ready_while_busy", 128'(req_ready), 128'd0);
                if (hold) begin
                    check("stall_valid", 128'(cmd_tvalid), 128'd1);
                    check("stall_data", cmd_tdata, hold_data);
                    check("stall_last", 128'(cmd_tlast), 128'(hold_last));
                end
                hold = 1'b0;
                if (cmd_tvalid) begin
                    if (cmd_tready) begin
                        g.data = cmd_tdata;
                        g.last = cmd_tlast;
                        got_q.push_back(g);
                        if (exp_q.size() == 0) begin
                            check("unexpected_word", cmd_tdata, 128'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check("sb_data", cmd_tdata, e.data);
                            check("sb_last", 128'(cmd_tlast), 128'(e.last));
                        end
                    end else begin
                        hold      = 1'b1;
                        hold_data = cmd_tdata;
                        hold_last = cmd_tlast;
                    end
                end
            end
        end
    end

    // Reference model: builds the word list straight from the encoding rules.
    task automatic model_push(input logic [6:0] m, input logic [47:0] freq, input logic [13:0] amp,
                              input logic [13:0] phase, input logic [13:0] aoff,
                              input logic [59:0] toff, input logic [63:0] ts);
        logic [47:0] f, d;
        logic [13:0] a, p;
        logic [3:0]  ops[$];
        logic [59:0] pls[$];
        int          best;
        word_t       w;
        f = m[0] ? freq : sh_freq;
        a = m[1] ? amp : sh_amp;
        p = m[2] ? phase : sh_phase;
        if (m[4]) begin ops.push_back(4'h4); pls.push_back(toff); end
        if (m[3]) begin ops.push_back(4'h5); pls.push_back(60'(aoff)); end
        if (m[5]) begin
            if (m[1] || m[2]) begin ops.push_back(4'h0); pls.push_back({a, p, f[47:16]}); end
            ops.push_back(4'h1);
            pls.push_back(60'(f));
        end else if (m[2:0] != 3'b000) begin
            d = f ^ sh_freq;
            best = -1;
            if (!m[6]) begin
                for (int lo = 16; lo >= 0; lo -= 2) begin
                    if (best < 0 && (d >> (lo + 32)) == 48'd0 && (d % (48'd1 << lo)) == 48'd0)
                        best = lo;
                end
            end
            if (best >= 0) begin
                ops.push_back(best == 16 ? 4'h0 : 4'(8 + (14 - best) / 2));
                pls.push_back({a, p, 32'(f >> best)});
            end else begin
                ops.push_back(4'h0);
                pls.push_back({a, p, f[47:16]});
                ops.push_back(4'hF);
                pls.push_back({a, p, f[31:0]});
            end
        end
        for (int i = 0; i < ops.size(); i++) begin
            w.data = {ts + 64'(i), ops[i], pls[i]};
            w.last = (i == ops.size() - 1);
            exp_q.push_back(w);
        end
        sh_freq  = f;
        sh_amp   = a;
        sh_phase = p;
    endtask

    task automatic issue_req(input logic [6:0] m, input logic [47:0] f, input logic [13:0] a,
                             input logic [13:0] p, input logic [13:0] o,
                             input logic [59:0] t, input logic [63:0] ts);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("ready_timeout", 128'd0, 128'd1);
        model_push(m, f, a, p, o, t, ts);
        req_mask = m; req_freq = f; req_amp = a; req_phase = p;
        req_amp_offset = o; req_time_offset = t; req_timestamp = ts;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while ((busy || cmd_tvalid || exp_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("done_timeout", 128'(exp_q.size()), 128'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("rst_tvalid", 128'(cmd_tvalid), 128'd0);
        check("rst_tdata", cmd_tdata, 128'd0);
        check("rst_tlast", 128'(cmd_tlast), 128'd0);
        check("rst_ready", 128'(req_ready), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        exp_q.delete();
        got_q.delete();
        sh_freq = '0; sh_amp = '0; sh_phase = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        logic [47:0] f;
        logic [63:0] ts;
        int          n;

        // Single partial-frequency word, plus first-word latency.
        do_reset();
        issue_req(7'h01, 48'h0000_0000_0100, 14'h0, 14'h0, 14'h0, 60'h0, 64'd100);
        @(negedge clk);
        check("lat_plan_tvalid", 128'(cmd_tvalid), 128'd0);
        @(negedge clk);
        check("lat_emit_tvalid", 128'(cmd_tvalid), 128'd1);
        wait_done();
        check("t1_count", 128'(got_q.size()), 128'd1);
        if (got_q.size() >= 1) begin
            check("t1_word", got_q[0].data, {64'd100, 4'hB, 14'd0, 14'd0, 32'h1});
            check("t1_last", 128'(got_q[0].last), 128'd1);
        end

        do_reset();
        issue_req(7'h03, 48'h1234_5678_0000, 14'h3FFF, 14'h0123, 14'h0, 60'h0, 64'd20);
        wait_done();
        check("t2_count", 128'(got_q.size()), 128'd1);
        if (got_q.size() >= 1)
            check("t2_word", got_q[0].data, {64'd20, 4'h0, 14'h3FFF, 14'd0, 32'h1234_5678});

        do_reset();
        issue_req(7'h01, 48'h8000_0000_0001, 14'h0, 14'h0, 14'h0, 60'h0, 64'd7);
        wait_done();
        check("t3_count", 128'(got_q.size()), 128'd2);
        if (got_q.size() >= 2) begin
            check("t3_word0", got_q[0].data, {64'd7, 4'h0, 28'd0, 32'h8000_0000});
            check("t3_word1", got_q[1].data, {64'd8, 4'hF, 28'd0, 32'h1});
            check("t3_last0", 128'(got_q[0].last), 128'd0);
        end

        // Full mask with sync, stalled for five cycles after the first word.
        do_reset();
        issue_req(7'h3F, 48'hABCD_EF01_2345, 14'h1111, 14'h2222, 14'h0333,
                  60'h0FED_CBA9_8765_432, 64'd0);
        n = 0;
        while (got_q.size() < 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        stall_force = 1'b1;
        @(posedge clk);
        repeat (5) begin
            @(negedge clk);
            check("t4_stall_tvalid", 128'(cmd_tvalid), 128'd1);
            check("t4_stall_ready", 128'(req_ready), 128'd0);
        end
        stall_force = 1'b0;
        wait_done();
        check("t4_count", 128'(got_q.size()), 128'd4);
        if (got_q.size() >= 4) begin
            check("t4_w0", got_q[0].data, {64'd0, 4'h4, 60'h0FED_CBA9_8765_432});
            check("t4_w1", got_q[1].data, {64'd1, 4'h5, 46'd0, 14'h0333});
            check("t4_w2", got_q[2].data, {64'd2, 4'h0, 14'h1111, 14'h2222, 32'hABCD_EF01});
            check("t4_w3", got_q[3].data, {64'd3, 4'h1, 12'd0, 48'hABCD_EF01_2345});
            check("t4_last", 128'({got_q[0].last, got_q[1].last, got_q[2].last, got_q[3].last}), 128'b0001);
        end

        // Reset while stalled in EMIT, then encode against zeroed shadows.
        stall_force = 1'b1;
        issue_req(7'h5F, 48'h5555_0000_AAAA, 14'h0AAA, 14'h1555, 14'h0001, 60'h1, 64'd50);
        n = 0;
        while (!cmd_tvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_tvalid_before_rst", 128'(cmd_tvalid), 128'd1);
        do_reset();
        stall_force = 1'b0;
        issue_req(7'h01, 48'h0000_0000_0100, 14'h0, 14'h0, 14'h0, 60'h0, 64'd5);
        wait_done();
        check("t5_count", 128'(got_q.size()), 128'd1);
        if (got_q.size() >= 1)
            check("t5_word", got_q[0].data, {64'd5, 4'hB, 28'd0, 32'h1});

        // Randomized requests against the model with random backpressure.
        rand_mode = 1'b1;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0:       f = 48'({$urandom(), $urandom()});
                1:       f = sh_freq ^ (48'($urandom()) << $urandom_range(0, 16));
                2:       f = sh_freq;
                default: f = sh_freq ^ (48'd1 << $urandom_range(0, 47));
            endcase
            ts = (i % 10 == 0) ? 64'hFFFF_FFFF_FFFF_FFFE : {$urandom(), $urandom()};
            issue_req(7'($urandom_range(0, 127)), f, 14'($urandom()), 14'($urandom()),
                      14'($urandom()), 60'({$urandom(), $urandom()}), ts);
        end
        wait_done();
        rand_mode = 1'b0;
        check("leftover_expected", 128'(exp_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
